// File: rtl/ch_pkg.sv
// Shared definitions for the channel transfer engine: state encoding,
// beat geometry and data-path width.
package ch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SRC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam int BEAT_BYTES = 8;
  localparam int BEAT_SHIFT = 3;
  localparam int DATA_W     = 64;

endpackage

// File: rtl/ch_xfer_ctrl_if.sv
// Bus bundle between the transfer engine and its surroundings: memory read
// stream, source FIFO push side, destination FIFO drain side and memory
// write stream. master = engine side, slave = FIFO/memory side.
interface ch_xfer_ctrl_if;
  import ch_pkg::*;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_dat;

  logic              src_xfer;
  logic              src_last;
  logic [31:0]       src_dat_o;
  logic [31:0]       src_dat64_o;
  logic              src_start;
  logic              src_stop;

  logic              dst_xfer;
  logic              dst_start;
  logic              dst_stop;
  logic              dst_end;
  logic [31:0]       dst_dat_i;
  logic [31:0]       dst_dat64_i;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_dat;

  modport master (
    input  rd_valid, rd_dat, src_start, src_stop,
    input  dst_start, dst_stop, dst_end, dst_dat_i, dst_dat64_i, wr_ready,
    output rd_ready, src_xfer, src_last, src_dat_o, src_dat64_o,
    output dst_xfer, wr_valid, wr_dat
  );

  modport slave (
    output rd_valid, rd_dat, src_start, src_stop,
    output dst_start, dst_stop, dst_end, dst_dat_i, dst_dat64_i, wr_ready,
    input  rd_ready, src_xfer, src_last, src_dat_o, src_dat64_o,
    input  dst_xfer, wr_valid, wr_dat
  );

endinterface

// File: rtl/ch_xfer_oreg.sv
// Single-entry 64-bit output register for the write stream. "free" says a
// new word may be loaded this cycle (empty, or being taken right now).
module ch_xfer_oreg
  import ch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic              ready,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] dout,
  output logic              free
);

  assign free = ~valid | ready;

  // Hold one write beat; flush drops a pending beat on job kill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ch_xfer_ctrl.sv
// Channel transfer engine: pushes ceil(dc/8) read beats into the source FIFO
// (last one tagged) and drains the destination FIFO into the write stream
// until the end marker sits at the FIFO head.
// Optional watchdog: define CH_XFER_TIMEOUT_EN to kill a stalled job.
module ch_xfer_ctrl
  import ch_pkg::*;
#(
  parameter int DC_W   = 24,
  parameter int OCNT_W = 16,
  parameter int TMO_W  = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              go,
  input  logic              abort,
  input  logic [DC_W-1:0]   dc,
  ch_xfer_ctrl_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [OCNT_W-1:0] ocnt
);

  if (TMO_W < 2 || DC_W <= BEAT_SHIFT) begin : g_param_chk
    $error("ch_xfer_ctrl: TMO_W must be >= 2 and DC_W > BEAT_SHIFT");
  end

  state_t            state, state_nxt;
  logic [DC_W:0]     beats;
  logic [DC_W:0]     beats_init;
  logic              active, kill, tmo_hit;
  logic              src_xfer, src_last, dst_xfer;
  logic              wr_valid, free, wr_hs;

  // One extra bit so dc near all-ones cannot wrap before the shift.
  assign beats_init = ({1'b0, dc} + (DC_W+1)'(BEAT_BYTES - 1)) >> BEAT_SHIFT;
  assign active     = (state == ST_SRC) || (state == ST_DRAIN);
  assign kill       = active & (abort | tmo_hit);
  assign wr_hs      = wr_valid & bus.wr_ready;

`ifdef CH_XFER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  // Watchdog: counts cycles without any push, pop or write handshake.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_cnt <= '0;
    end else if (!active || src_xfer || dst_xfer || wr_hs) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit = active & (tmo_cnt == '1);
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and transfer strobes; push/pop are suppressed in a kill cycle.
  always_comb begin
    state_nxt = state;
    src_xfer  = 1'b0;
    src_last  = 1'b0;
    dst_xfer  = 1'b0;
    if (state == ST_SRC && !kill) begin
      src_xfer = bus.rd_valid & bus.src_start & ~bus.src_stop & (beats != '0);
    end else begin
      src_xfer = 1'b0;
    end
    src_last = src_xfer & (beats == (DC_W+1)'(1));
    if (active && !kill) begin
      dst_xfer = bus.dst_start & ~bus.dst_end & free;
    end else begin
      dst_xfer = 1'b0;
    end
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nxt = (dc == '0) ? ST_FIN : ST_SRC;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SRC: begin
        if (kill) begin
          state_nxt = ST_FIN;
        end else if (src_last) begin
          state_nxt = ST_DRAIN;
        end else begin
          state_nxt = ST_SRC;
        end
      end
      ST_DRAIN: begin
        if (kill) begin
          state_nxt = ST_FIN;
        end else if (bus.dst_start && bus.dst_end && !wr_valid) begin
          state_nxt = ST_FIN;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register plus job bookkeeping: remaining beats, error flag, beat count.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      beats <= '0;
      err   <= 1'b0;
      ocnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && go) begin
        beats <= beats_init;
        err   <= 1'b0;
        ocnt  <= '0;
      end else begin
        if (kill) begin
          beats <= '0;
          err   <= 1'b1;
        end else if (src_xfer) begin
          beats <= beats - (DC_W+1)'(1);
        end
        if (wr_hs && ocnt != '1) begin
          ocnt <= ocnt + OCNT_W'(1);
        end
      end
    end
  end

  ch_xfer_oreg u_oreg (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .load  (dst_xfer),
    .flush (kill),
    .ready (bus.wr_ready),
    .din   ({bus.dst_dat64_i, bus.dst_dat_i}),
    .valid (wr_valid),
    .dout  (bus.wr_dat),
    .free  (free)
  );

  assign bus.rd_ready    = src_xfer;
  assign bus.src_xfer    = src_xfer;
  assign bus.src_last    = src_last;
  assign bus.src_dat_o   = bus.rd_dat[31:0];
  assign bus.src_dat64_o = bus.rd_dat[63:32];
  assign bus.dst_xfer    = dst_xfer;
  assign bus.wr_valid    = wr_valid;
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_FIN);

endmodule

// File: tb/tb_ch_xfer_ctrl.sv
// Scoreboard bench for ch_xfer_ctrl: expected source beats are queued at job
// start, expected write words when the destination FIFO model is filled.
module tb_ch_xfer_ctrl;
  import ch_pkg::*;

  localparam int DC_W   = 24;
  localparam int OCNT_W = 16;
`ifdef CH_XFER_TIMEOUT_EN
  localparam int TMO_W  = 4;
`else
  localparam int TMO_W  = 16;
`endif

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              go, abort;
  logic [DC_W-1:0]   dc;
  logic              busy, done, err;
  logic [OCNT_W-1:0] ocnt;

  ch_xfer_ctrl_if bus ();

  ch_xfer_ctrl #(.DC_W(DC_W), .OCNT_W(OCNT_W), .TMO_W(TMO_W)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .go       (go),
    .abort    (abort),
    .dc       (dc),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ocnt     (ocnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [64:0] src_q[$];
  logic [63:0] wr_q[$];
  logic [63:0] dfifo[$];
  logic        marker = 1'b0;
  logic        toggle_ready = 1'b0;
  int          job_id = 0;
  int          rd_idx = 0;
  logic        cap_src = 1'b0;
  logic        cap_dst = 1'b0;
  int          src_total = 0;
  int          dst_total = 0;

  function automatic logic [63:0] beat_data(input int job, input int idx);
    return {16'hC0DE, job[15:0], 16'h5A00, idx[15:0]};
  endfunction

  // Output monitor: pops scoreboards on every push and write handshake.
  always @(negedge wb_clk_i) begin
    cap_src = 1'b0;
    cap_dst = 1'b0;
    if (!wb_rst_i) begin
      cap_src = bus.src_xfer;
      cap_dst = bus.dst_xfer;
      if (bus.src_xfer) begin
        src_total++;
        if (src_q.size() == 0) check_eq("src_unexpected", 65'(bus.src_xfer), 65'd0);
        else check_eq("src_beat", {bus.src_last, bus.src_dat64_o, bus.src_dat_o}, src_q.pop_front());
      end
      if (bus.dst_xfer) begin
        dst_total++;
        check_eq("dst_when_free", 65'((!bus.wr_valid) || bus.wr_ready), 65'd1);
      end
      if (bus.wr_valid && bus.wr_ready) begin
        if (wr_q.size() == 0) check_eq("wr_unexpected", 65'(bus.wr_valid), 65'd0);
        else check_eq("wr_dat", {1'b0, bus.wr_dat}, {1'b0, wr_q.pop_front()});
      end
    end
  end

  task automatic refresh();
    logic [63:0] head;
    head = (dfifo.size() != 0) ? dfifo[0] : 64'd0;
    bus.dst_start   = (dfifo.size() != 0) || marker;
    bus.dst_end     = (dfifo.size() == 0) && marker;
    bus.dst_stop    = (dfifo.size() >= 3);
    bus.dst_dat_i   = head[31:0];
    bus.dst_dat64_i = head[63:32];
    bus.rd_dat      = beat_data(job_id, rd_idx);
  endtask

  task automatic cycle();
    @(posedge wb_clk_i);
    #1;
    if (cap_dst && dfifo.size() != 0) dfifo.delete(0);
    if (cap_src) rd_idx++;
    if (toggle_ready) bus.wr_ready = ~bus.wr_ready;
    refresh();
  endtask

  task automatic settle();
    @(negedge wb_clk_i);
    #1;
  endtask

  task automatic start_job(input int dcv);
    int n;
    job_id++;
    rd_idx = 0;
    n = (dcv + 7) / 8;
    for (int i = 0; i < n; i++) src_q.push_back({(i == n - 1), beat_data(job_id, i)});
    dc = DC_W'(dcv);
    go = 1'b1;
    refresh();
    cycle();
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input logic exp_err, output int elapsed);
    logic seen;
    seen = 1'b0;
    elapsed = 0;
    while (!seen && elapsed <= budget) begin
      settle();
      if (done) seen = 1'b1;
      else begin
        cycle();
        elapsed++;
      end
    end
    if (seen) check_eq({tag, "_err"}, 65'(err), 65'(exp_err));
    else check_eq({tag, "_done"}, 65'(done), 65'd1);
    marker = 1'b0;
    refresh();
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int el, s0, d0;
    wb_rst_i = 1'b1; go = 1'b0; abort = 1'b0; dc = '0;
    bus.rd_valid = 1'b0; bus.src_start = 1'b0; bus.src_stop = 1'b0; bus.wr_ready = 1'b0;
    refresh();
    repeat (3) @(posedge wb_clk_i);
    settle();
    check_eq("rst_busy", 65'(busy), 65'd0);
    check_eq("rst_done", 65'(done), 65'd0);
    check_eq("rst_err", 65'(err), 65'd0);
    check_eq("rst_ocnt", 65'(ocnt), 65'd0);
    check_eq("rst_wr_valid", 65'(bus.wr_valid), 65'd0);
    check_eq("rst_wr_dat", 65'(bus.wr_dat), 65'd0);
    check_eq("rst_strobes", 65'({bus.src_xfer, bus.src_last, bus.dst_xfer, bus.rd_ready}), 65'd0);
    wb_rst_i = 1'b0;
    cycle();

    // dc=24: three back-to-back pushes, last tagged on the third.
    bus.src_start = 1'b1; bus.rd_valid = 1'b1; bus.wr_ready = 1'b1;
    start_job(24);
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("t1_src_xfer", 65'(bus.src_xfer), 65'd1);
      check_eq("t1_rd_ready", 65'(bus.rd_ready), 65'd1);
      cycle();
    end
    settle();
    check_eq("t1_state_drain", 65'(dut.state), 65'd2);
    check_eq("t1_no_more_src", 65'(bus.src_xfer), 65'd0);
    check_eq("t1_srcq_empty", 65'(src_q.size()), 65'd0);
    marker = 1'b1; refresh();
    wait_done("t1", 20, 1'b0, el);

    // dc=13: two beats with a five-cycle src_stop stall between them.
    start_job(13);
    settle();
    check_eq("t2_beat1", 65'(bus.src_xfer), 65'd1);
    cycle();
    bus.src_stop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_eq("t2_stall", 65'(bus.src_xfer), 65'd0);
      cycle();
    end
    bus.src_stop = 1'b0;
    settle();
    check_eq("t2_beat2", 65'(bus.src_xfer), 65'd1);
    check_eq("t2_last", 65'(bus.src_last), 65'd1);
    marker = 1'b1; refresh();
    wait_done("t2", 20, 1'b0, el);

    // Drain four entries then the marker with wr_ready toggling.
    d0 = dst_total;
    for (int i = 0; i < 4; i++) begin
      dfifo.push_back({32'hD000_0000 + 32'(i), 32'h1234_0000 + 32'(i * 3)});
      wr_q.push_back({32'hD000_0000 + 32'(i), 32'h1234_0000 + 32'(i * 3)});
    end
    marker = 1'b1;
    bus.wr_ready = 1'b1; toggle_ready = 1'b1;
    start_job(8);
    wait_done("t3", 60, 1'b0, el);
    check_eq("t3_ocnt", 65'(ocnt), 65'd4);
    check_eq("t3_wrq_empty", 65'(wr_q.size()), 65'd0);
    check_eq("t3_pops", 65'(dst_total - d0), 65'd4);
    check_eq("t3_wr_valid", 65'(bus.wr_valid), 65'd0);
    toggle_ready = 1'b0; bus.wr_ready = 1'b1;

    // dc=0: immediate completion, no transfers.
    s0 = src_total; d0 = dst_total;
    start_job(0);
    wait_done("t4", 5, 1'b0, el);
    check_eq("t4_latency", 65'(el), 65'd0);
    check_eq("t4_no_xfer", 65'((src_total - s0) + (dst_total - d0)), 65'd0);

    // Abort with five beats left, then a normal one-beat job.
    s0 = src_total;
    start_job(64);
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("t5_push", 65'(bus.src_xfer), 65'd1);
      cycle();
    end
    abort = 1'b1;
    settle();
    check_eq("t5_abort_strobes", 65'({bus.src_xfer, bus.dst_xfer}), 65'd0);
    cycle();
    abort = 1'b0;
    src_q.delete();
    settle();
    check_eq("t5_done", 65'(done), 65'd1);
    check_eq("t5_err", 65'(err), 65'd1);
    cycle();
    settle();
    check_eq("t5_busy_after", 65'(busy), 65'd0);
    check_eq("t5_err_hold", 65'(err), 65'd1);
    check_eq("t5_push_count", 65'(src_total - s0), 65'd3);
    marker = 1'b1; refresh();
    start_job(8);
    wait_done("t5b", 20, 1'b0, el);
    check_eq("t5b_srcq_empty", 65'(src_q.size()), 65'd0);

    // Stalled job: watchdog kill, or indefinite wait without it.
    bus.rd_valid = 1'b0;
    start_job(16);
`ifdef CH_XFER_TIMEOUT_EN
    wait_done("t6_tmo", 40, 1'b1, el);
    check_eq("t6_latency", 65'(el), 65'd16);
`else
    repeat (100) cycle();
    settle();
    check_eq("t6_still_busy", 65'(busy), 65'd1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    wait_done("t6_abort", 5, 1'b1, el);
`endif
    src_q.delete();

    check_eq("end_wrq_empty", 65'(wr_q.size()), 65'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
